program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, 32, number of 16-bit words in program memory (maximum word count).
REQ-002 SHALL have parameter ADDR_WIDTH, 5, width of mem_addr.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  single-cycle request to begin a new load.
REQ-006 SHALL have port in_data  input  8  incoming program byte.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  program memory write address.
REQ-010 SHALL have port mem_write_data  output  16  program memory write word.
REQ-011 SHALL have port mem_write  output  1  program memory write strobe.
REQ-012 SHALL have port start_execution  output  1  program loaded and verified; CPU may run.
REQ-013 SHALL have port load_error  output  1  last load failed.
REQ-014 SHALL have port words_loaded  output  ADDR_WIDTH+1  words written in the current or last load.

Function
REQ-015 SHALL accept a byte only on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL implement states IDLE, COUNT, HI, LO, WRITE, CHECK, RUN, ERROR.
REQ-017 SHALL assert in_ready only in COUNT, HI, LO and CHECK; in_ready SHALL be a function of state only.
REQ-018 IDLE: load_start=1 -> COUNT; clears words_loaded, load_error, the running checksum and the stored word count N.
REQ-019 COUNT: accepted byte is N; 1<=N<=MEM_DEPTH -> HI; N=0 or N>MEM_DEPTH -> ERROR.
REQ-020 HI: accepted byte -> word[15:8], XORed into checksum, next state LO.
REQ-021 LO: accepted byte -> word[7:0], XORed into checksum, next state WRITE.
REQ-022 WRITE: SHALL hold mem_write=1 for exactly one cycle with mem_addr=words_loaded[ADDR_WIDTH-1:0] and mem_write_data={hi,lo}.
REQ-023 WRITE: SHALL increment words_loaded; SHALL go to CHECK if the incremented value equals N, else HI.
REQ-024 CHECK: accepted byte equal to the running XOR of all 2N data bytes -> RUN, else -> ERROR.
REQ-025 RUN: start_execution=1 (registered) continuously until reset or load_start.
REQ-026 ERROR: load_error=1 (registered) continuously until reset or load_start.
REQ-027 load_start in RUN or ERROR SHALL go to COUNT with the same clears as REQ-018 and deassert start_execution/load_error on the same edge.
REQ-028 load_start in COUNT, HI, LO, WRITE or CHECK SHALL be ignored.
REQ-029 mem_write SHALL be 0 in every state except WRITE; mem_addr and mem_write_data SHALL hold their last values outside WRITE.
REQ-030 A byte presented with in_valid=1 while in_ready=0 SHALL not be consumed and SHALL not affect the checksum.
REQ-031 Minimum load time for N words SHALL be 1+3N+1 accepted-or-write cycles after COUNT is entered; in_valid gaps SHALL only stall the current state.
REQ-032 The word count SHALL never cause mem_addr to wrap; the highest write address SHALL be N-1.

Reset
REQ-033 reset=1 SHALL asynchronously force state IDLE and in_ready, mem_addr, mem_write_data, mem_write, start_execution, load_error, words_loaded, N and checksum to 0.
REQ-034 reset asserted mid-load SHALL abandon the load; no further mem_write SHALL occur until a new load_start.

Verification
REQ-035 load_start; bytes 02,11,22,33,44,checksum 44 -> writes 0x1122@0, 0x3344@1, one cycle each; start_execution=1, words_loaded=2.
REQ-036 Same stream with checksum 00 -> both writes occur, load_error=1, start_execution=0.
REQ-037 Count byte 00 and separately 21 (33) -> ERROR immediately, no mem_write, in_ready=0.
REQ-038 N=32, random words, in_valid toggled randomly -> 32 writes at addresses 0..31 in order, no extra writes, start_execution=1.
REQ-039 reset pulsed after 3 bytes of a 4-word load -> all outputs 0, IDLE; a subsequent full load completes normally.
REQ-040 In RUN, load_start with in_valid=1 on the same cycle -> start_execution=0 next cycle, byte not consumed that cycle, next accepted byte taken as N.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: count byte, N big-endian words, XOR checksum.
// Writes each word to program memory, then releases the CPU or flags an error.
module program_loader #(
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_write_data,
  output logic                  mem_write,
  output logic                  start_execution,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    WRITE,
    CHECK,
    RUN,
    ERROR
  } state_t;

  localparam logic [7:0]          MAX_N = 8'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  state_t                state_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic [ADDR_WIDTH:0]   words_d;
  logic [7:0]            sum_q;
  logic [7:0]            hi_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           data_q;
  logic                  wr_q;
  logic                  run_q;
  logic                  err_q;
  logic                  accept;
  logic                  bad_count;

  // Ready depends on state alone, so a byte never races the transition.
  always_comb begin
    in_ready = 1'b0;
    unique case (1'b1)
      state_q == COUNT: in_ready = 1'b1;
      state_q == HI:    in_ready = 1'b1;
      state_q == LO:    in_ready = 1'b1;
      state_q == CHECK: in_ready = 1'b1;
      default:          in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign words_d   = words_q + ONE;
  assign bad_count = (in_data == 8'd0) || (in_data > MAX_N);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      words_q <= '0;
      sum_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q <= COUNT;
            n_q     <= '0;
            words_q <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
          end
        end
        COUNT: begin
          if (accept) begin
            if (bad_count) begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end else begin
              n_q     <= in_data[ADDR_WIDTH:0];
              state_q <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            hi_q    <= in_data;
            sum_q   <= sum_q ^ in_data;
            state_q <= LO;
          end
        end
        LO: begin
          if (accept) begin
            sum_q   <= sum_q ^ in_data;
            addr_q  <= words_q[ADDR_WIDTH-1:0];
            data_q  <= {hi_q, in_data};
            wr_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          words_q <= words_d;
          state_q <= (words_d == n_q) ? CHECK : HI;
        end
        CHECK: begin
          if (accept) begin
            if (in_data == sum_q) begin
              state_q <= RUN;
              run_q   <= 1'b1;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        RUN, ERROR: begin
          if (load_start) begin
            state_q <= COUNT;
            n_q     <= '0;
            words_q <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr        = addr_q;
  assign mem_write_data  = data_q;
  assign mem_write       = wr_q;
  assign start_execution = run_q;
  assign load_error      = err_q;
  assign words_loaded    = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: driver queues expected writes,
// a negedge monitor pops and compares them as mem_write appears.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  mem_addr;
  logic [15:0] mem_write_data;
  logic        mem_write;
  logic        start_execution;
  logic        load_error;
  logic [5:0]  words_loaded;

  int errors = 0;
  int checks = 0;
  logic [20:0] exp_q[$];
  logic [20:0] mon_e;
  logic        prev_mw = 1'b0;

  program_loader #(.MEM_DEPTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock),
    .reset(reset),
    .load_start(load_start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_write(mem_write),
    .start_execution(start_execution),
    .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mem_write) begin
      chk("write_one_cycle", 32'(prev_mw), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required none",
                 mem_addr, mem_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(mon_e[20:16]));
        chk("write_data", 32'(mem_write_data), 32'(mon_e[15:0]));
      end
    end
    prev_mw = mem_write;
  end

  task automatic pulse_start();
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0, required 1");
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_words(input logic [15:0] w[$], input logic [7:0] cs,
                            input bit gaps);
    for (int i = 0; i < w.size(); i++) exp_q.push_back({5'(i), w[i]});
    send_byte(8'(w.size()), gaps);
    for (int i = 0; i < w.size(); i++) begin
      send_byte(w[i][15:8], gaps);
      send_byte(w[i][7:0], gaps);
    end
    send_byte(cs, gaps);
  endtask

  task automatic chk_status(input string tag, input logic run,
                            input logic err, input logic [5:0] wl);
    chk({tag, "_start_exec"}, 32'(start_execution), 32'(run));
    chk({tag, "_load_error"}, 32'(load_error), 32'(err));
    chk({tag, "_words"}, 32'(words_loaded), 32'(wl));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_data"}, 32'(mem_write_data), 32'd0);
    chk({tag, "_start_exec"}, 32'(start_execution), 32'd0);
    chk({tag, "_load_error"}, 32'(load_error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w[$];
    logic [7:0]  cs;
    reset      = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (2) @(negedge clock);
    chk("idle_no_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    pulse_start();
    w = '{16'h1122, 16'h3344};
    send_words(w, 8'h44, 1'b0);
    repeat (2) @(negedge clock);
    chk_status("good2", 1'b1, 1'b0, 6'd2);
    chk("hold_addr", 32'(mem_addr), 32'd1);
    chk("hold_data", 32'(mem_write_data), 32'h3344);

    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h01;
    @(negedge clock);
    load_start = 1'b0;
    chk("restart_start_exec", 32'(start_execution), 32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    chk("restart_words", 32'(words_loaded), 32'd0);
    exp_q.push_back({5'd0, 16'hABCD});
    send_byte(8'h01, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'h66, 1'b0);
    repeat (2) @(negedge clock);
    chk_status("restart", 1'b1, 1'b0, 6'd1);

    pulse_start();
    send_words(w, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    chk_status("badsum", 1'b0, 1'b1, 6'd2);

    pulse_start();
    send_byte(8'h00, 1'b0);
    repeat (2) @(negedge clock);
    chk_status("count00", 1'b0, 1'b1, 6'd0);

    pulse_start();
    send_byte(8'h21, 1'b0);
    repeat (2) @(negedge clock);
    chk_status("count21", 1'b0, 1'b1, 6'd0);

    w  = {};
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      w.push_back(16'($urandom));
      cs = cs ^ w[i][15:8] ^ w[i][7:0];
    end
    pulse_start();
    send_words(w, cs, 1'b1);
    repeat (2) @(negedge clock);
    chk_status("full32", 1'b1, 1'b0, 6'd32);
    chk("full32_last_addr", 32'(mem_addr), 32'd31);

    pulse_start();
    exp_q.push_back({5'd0, 16'h1234});
    send_byte(8'h04, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_reset_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("post_reset_sb_empty", 32'(exp_q.size()), 32'd0);

    pulse_start();
    w = '{16'hBEEF, 16'h0102, 16'hF00D};
    send_words(w, 8'hAF, 1'b1);
    repeat (2) @(negedge clock);
    chk_status("reload", 1'b1, 1'b0, 6'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
